// File: rtl/spi_display_tx.sv
// SPI mode-0 transmitter for a display controller: sends one 32-bit word MSB first
// with chip select and a data/command line, then holds csn high for a gap.
module spi_display_tx #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tx_valid,
    output logic        tx_ready,
    input  logic [31:0] tx_data,
    input  logic        tx_dc,
    output logic        spi_sclk,
    output logic        spi_sdo,
    output logic        dc,
    output logic        csn,
    output logic        busy,
    output logic        done
);

    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int GAP_W = $clog2(CS_GAP) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOW,
        HIGH,
        HOLD,
        GAP
    } state_t;

    state_t           state, state_next;
    logic [DIV_W-1:0] div_cnt, div_next;
    logic [GAP_W-1:0] gap_cnt, gap_next;
    logic [4:0]       bit_cnt, bit_next;
    logic [30:0]      shift, shift_next;
    logic             sclk_next, sdo_next, csn_next, dc_next, done_next;
    logic             div_last;

    assign tx_ready = (state == IDLE) && !reset;
    assign busy     = (state != IDLE);
    assign div_last = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            div_cnt  <= '0;
            gap_cnt  <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            spi_sclk <= 1'b0;
            spi_sdo  <= 1'b0;
            csn      <= 1'b1;
            dc       <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_next;
            div_cnt  <= div_next;
            gap_cnt  <= gap_next;
            bit_cnt  <= bit_next;
            shift    <= shift_next;
            spi_sclk <= sclk_next;
            spi_sdo  <= sdo_next;
            csn      <= csn_next;
            dc       <= dc_next;
            done     <= done_next;
        end
    end

    // Every output is computed here as the value it takes after the next edge,
    // so all SPI pins come straight from flops.
    always_comb begin
        state_next = state;
        div_next   = div_cnt;
        gap_next   = gap_cnt;
        bit_next   = bit_cnt;
        shift_next = shift;
        sclk_next  = spi_sclk;
        sdo_next   = spi_sdo;
        csn_next   = csn;
        dc_next    = dc;
        done_next  = 1'b0;

        case (state)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    state_next = LOW;
                    shift_next = tx_data[30:0];
                    sdo_next   = tx_data[31];
                    dc_next    = tx_dc;
                    csn_next   = 1'b0;
                    sclk_next  = 1'b0;
                    bit_next   = 5'd31;
                    div_next   = '0;
                end
            end
            LOW: begin
                if (div_last) begin
                    state_next = HIGH;
                    sclk_next  = 1'b1;
                    div_next   = '0;
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            HIGH: begin
                if (div_last) begin
                    div_next  = '0;
                    sclk_next = 1'b0;
                    // Data advances only on the falling edge so it is stable at each rise.
                    if (bit_cnt == 5'd0) begin
                        state_next = HOLD;
                    end else begin
                        state_next = LOW;
                        bit_next   = bit_cnt - 1'b1;
                        sdo_next   = shift[30];
                        shift_next = {shift[29:0], 1'b0};
                    end
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            HOLD: begin
                if (div_last) begin
                    state_next = GAP;
                    div_next   = '0;
                    gap_next   = '0;
                    csn_next   = 1'b1;
                    done_next  = 1'b1;
                end else begin
                    div_next = div_cnt + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = IDLE;
                    gap_next   = '0;
                end else begin
                    gap_next = gap_cnt + 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule
